// File: rtl/tdm_demux4_pkg.sv
// tdm_pkg: shared definitions for the 4-slot TDM link (receiver tdm_demux4
// and the future tdm_mux4 transmitter).
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  // Framing state: hunting for a start-of-frame, or running aligned
  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

  // Index of the final slot of a frame, sized to the slot counter
  function automatic logic [SLOT_W-1:0] last_slot();
    return SLOT_W'(NUM_SLOTS - 1);
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: serial input beat plus reconstructed parallel frame outputs.
// Optional macro TDM_DEMUX_FRAME_CNT_EN adds the frame_cnt output.
interface tdm_demux4_if #(
  parameter int W = 1
);
  import tdm_pkg::*;

  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_sof;
  logic [W-1:0]      out0;
  logic [W-1:0]      out1;
  logic [W-1:0]      out2;
  logic [W-1:0]      out3;
  logic              frame_valid;
  logic              frame_err;
  logic [SLOT_W-1:0] slot;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [7:0]        frame_cnt;
`endif

  modport master (
`ifdef TDM_DEMUX_FRAME_CNT_EN
    input  frame_cnt,
`endif
    output in_valid, in_data, in_sof,
    input  out0, out1, out2, out3, frame_valid, frame_err, slot
  );

  modport slave (
`ifdef TDM_DEMUX_FRAME_CNT_EN
    output frame_cnt,
`endif
    input  in_valid, in_data, in_sof,
    output out0, out1, out2, out3, frame_valid, frame_err, slot
  );

endinterface

// File: rtl/tdm_demux4_slot_ctr.sv
// tdm_slot_ctr: slot index of the next accepted sample. A start-of-frame
// sample always occupies slot 0, so load jumps straight to 1.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  // Load-to-1 wins over increment; increment wraps naturally 3 -> 0
  always_ff @(posedge clk) begin
    if (rst)
      slot <= '0;
    else if (load1)
      slot <= SLOT_W'(1);
    else if (inc)
      slot <= slot + SLOT_W'(1);
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of the 4-channel TDM link. Collects one sample
// per accepted beat, aligns on in_sof, and publishes complete frames.
// Optional macro TDM_DEMUX_FRAME_CNT_EN adds an 8-bit completed-frame counter.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 1
)(
  input  logic           clk,
  input  logic           rst,
  tdm_demux4_if.slave    bus
);

  tdm_state_t        state;
  logic [SLOT_W-1:0] slot;
  logic [W-1:0]      stage0, stage1, stage2;
  logic [W-1:0]      out0_q, out1_q, out2_q, out3_q;
  logic              frame_valid_q, frame_err_q;
  logic              slot_load, slot_inc;

  // A SOF beat always restarts at slot 0; ordinary beats advance only
  // while aligned and not sitting at a frame boundary
  assign slot_load = bus.in_valid & bus.in_sof;
  assign slot_inc  = (state == RUN) & bus.in_valid & ~bus.in_sof & (slot != '0);

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .load1 (slot_load),
    .inc   (slot_inc),
    .slot  (slot)
  );

  // Framing FSM with staging registers and registered frame outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HUNT;
      stage0        <= '0;
      stage1        <= '0;
      stage2        <= '0;
      out0_q        <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      out3_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state)
        HUNT: begin
          if (bus.in_valid && bus.in_sof) begin
            stage0 <= bus.in_data;
            state  <= RUN;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            if (bus.in_sof) begin
              stage0 <= bus.in_data;
              if (slot != '0)
                frame_err_q <= 1'b1;
            end else if (slot == '0) begin
              frame_err_q <= 1'b1;
              state       <= HUNT;
            end else if (slot == last_slot()) begin
              out0_q        <= stage0;
              out1_q        <= stage1;
              out2_q        <= stage2;
              out3_q        <= bus.in_data;
              frame_valid_q <= 1'b1;
            end else if (slot == SLOT_W'(1)) begin
              stage1 <= bus.in_data;
            end else begin
              stage2 <= bus.in_data;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.out0        = out0_q;
  assign bus.out1        = out1_q;
  assign bus.out2        = out2_q;
  assign bus.out3        = out3_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.slot        = slot;

`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Count published frames; errors do not clear it, 255 wraps to 0
  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt_q <= '0;
    else if (frame_valid_q)
      frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for tdm_demux4 (W=1). Expected frames are
// queued as their final beat is driven and retired on each frame_valid.
// Extra frame counter checks run when TDM_DEMUX_FRAME_CNT_EN is defined.
module tb_tdm_demux4;

  logic clk;
  logic rst;

  tdm_demux4_if #(.W(1)) bus ();

  tdm_demux4 #(.W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_compared   = 0;
  int         n_mismatched = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur_exp      = 4'h0;
  int         exp_err      = 0;
  int         frames_since_reset = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one beat at the falling edge; return just after it has been sampled
  task automatic applyStimulus(input logic v, input logic s, input logic d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Slot i carries p[i]; the frame is expected as {out3,out2,out1,out0} = p
  task automatic sendFrame(input logic [3:0] p, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        exp_q.push_back(p);
        frames_since_reset++;
      end
      applyStimulus(1'b1, (i == 0), p[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic doReset(input logic v, input logic s, input logic d);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    exp_q.delete();
    exp_err            = 0;
    cur_exp            = 4'h0;
    frames_since_reset = 0;
    @(posedge clk);
    #1;
    checkOutput("rst_slot", bus.slot, 0);
    checkOutput("rst_fv", bus.frame_valid, 0);
    checkOutput("rst_err", bus.frame_err, 0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle(2);
    checkOutput({tag, "_pending_frames"}, exp_q.size(), 0);
    checkOutput({tag, "_pending_errs"}, exp_err, 0);
  endtask

  // Monitor: retire expected frames/errors and check outputs every cycle
  always @(posedge clk) begin
    #1;
    if (bus.frame_valid) begin
      checkOutput("fv_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
    end
    if (bus.frame_err) begin
      checkOutput("err_expected", (exp_err > 0), 1);
      if (exp_err > 0) exp_err--;
    end
    checkOutput("fv_err_excl", bus.frame_valid & bus.frame_err, 0);
    checkOutput("outs", {bus.out3, bus.out2, bus.out1, bus.out0}, cur_exp);
  end

  // Stimulus sequence
  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    idle(5);
    checkOutput("idle_outs", {bus.out3, bus.out2, bus.out1, bus.out0}, 0);
    checkOutput("idle_fv", bus.frame_valid, 0);
    checkOutput("idle_err", bus.frame_err, 0);
    checkOutput("idle_slot", bus.slot, 0);

    // Frame 1,0,1,1 back-to-back
    sendFrame(4'b1101, 0);
    checkOutput("f1011_slot", bus.slot, 0);
    checkOutput("f1011_outs", {bus.out3, bus.out2, bus.out1, bus.out0}, 4'b1101);
    checkOutput("f1011_fv", bus.frame_valid, 1);
    idle(1);
    checkOutput("f1011_fv_pulse", bus.frame_valid, 0);
    drain("b2b");

    // All 16 patterns back-to-back
    for (int p = 0; p < 16; p++) sendFrame(4'(p), 0);
    drain("sweep");

    // Same frame with 3 idle cycles between slots
    sendFrame(4'b0000, 0);
    sendFrame(4'b1101, 3);
    drain("gaps");

    // Misaligned SOF restarts the frame
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    exp_err++;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("mis_slot", bus.slot, 1);
    checkOutput("mis_err", bus.frame_err, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    exp_q.push_back(4'b0100);
    frames_since_reset++;
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("mis_new_frame", {bus.out3, bus.out2, bus.out1, bus.out0}, 4'b0100);
    drain("misalign");

    // SOF with slot 0 is a clean start; missing SOF in RUN drops to HUNT
    sendFrame(4'b0110, 0);
    exp_err++;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("nosof_slot", bus.slot, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("hunt_drop_slot", bus.slot, 0);
    sendFrame(4'b1001, 1);
    drain("nosof");

    // Samples without SOF from reset are ignored
    doReset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    checkOutput("hunt_stream_slot", bus.slot, 0);

    // Reset mid-frame, overriding what would be the slot-3 beat
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("mid_slot", bus.slot, 3);
    doReset(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("post_rst_hunt_slot", bus.slot, 0);
    drain("midrst");

`ifdef TDM_DEMUX_FRAME_CNT_EN
    // Frame counter wraps after 256 frames
    doReset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 257; i++) sendFrame(4'($urandom_range(0, 15)), 0);
    drain("cnt");
    checkOutput("frame_cnt_257", bus.frame_cnt, 1);
    exp_err++;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    drain("cnt_err");
    checkOutput("frame_cnt_after_err", bus.frame_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive side of the 4-channel time-division link whose transmit side is the 4:1 mux driven by a rotating 2-bit select.
- Takes one serial sample per accepted beat plus a frame-start marker on slot 0.
- Reconstructs the four channels into parallel, double-buffered output registers.
- Pulses a frame-valid strobe when a complete, aligned frame of four slots has been received.

Parameters:
- W, 1, width of each channel sample in bits (1 = bit-level link, matching the 4:1 mux).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_sof carry a sample this cycle.
- in_data  input  W  serial sample for the current slot.
- in_sof  input  1  start of frame; qualifies in_data as slot 0. Ignored when in_valid=0.
- out0  output  W  channel 0 of last completed frame.
- out1  output  W  channel 1 of last completed frame.
- out2  output  W  channel 2 of last completed frame.
- out3  output  W  channel 3 of last completed frame.
- frame_valid  output  1  one-cycle pulse: out0..out3 updated this cycle.
- frame_err  output  1  one-cycle pulse: misaligned in_sof, partial frame discarded.
- slot  output  2  index the next accepted sample will occupy (0 in HUNT).

Behaviour:
- Reset (rst=1 at clock edge): state=HUNT; slot=0; out0..out3=0; staging regs=0; frame_valid=0; frame_err=0. Reset overrides any input that cycle, including mid-frame: the partial frame is dropped.
- States: HUNT, RUN.
- HUNT:
  - in_valid & in_sof: store in_data to stage[0], slot->1, go RUN.
  - in_valid & !in_sof: sample dropped, no error.
  - !in_valid: hold.
- RUN:
  - in_valid & !in_sof: store in_data to stage[slot], then slot+1.
  - When the accepted slot is 3: out0..out2 <= stage[0..2], out3 <= in_data, all in the same edge; frame_valid=1 next cycle; slot wraps to 0; stay RUN.
  - !in_valid: hold everything (gaps allowed anywhere in a frame, no timeout).
  - in_valid & in_sof with slot!=0: frame_err pulse; partial frame discarded (outputs untouched); this sample restarts as slot 0 (stage[0]<=in_data, slot->1); stay RUN.
  - in_valid & in_sof with slot==0: normal slot-0 accept, no error.
  - in_valid & !in_sof with slot==0: this is a missing SOF. frame_err pulse; sample dropped; go HUNT.
- Latency: frame_valid and new outputs are visible the cycle after the slot-3 beat is accepted.
- frame_valid and frame_err are registered, never both 1, and default to 0 each cycle.
- Outputs hold their values between frames.

Optional Feature:
- Macro TDM_DEMUX_FRAME_CNT_EN.
- Defined: adds output frame_cnt [7:0].
  - Reset 0.
  - Increments on every cycle frame_valid is asserted.
  - Wraps 255->0.
  - Not cleared by frame_err.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package tdm_pkg:
  - NUM_SLOTS=4, SLOT_W=2.
  - State enum (HUNT, RUN), also reused by the future tdm_mux4 transmitter.
- One sub-module: tdm_slot_ctr. Owns the 2-bit slot counter with load-to-1 on SOF, increment on accept, and wrap. The FSM and staging regs stay in the top module.

Test Plan:
- Reset then in_valid=0 for 5 cycles -> outputs all 0, frame_valid=0, frame_err=0, slot=0.
- W=1, frame bits 1,0,1,1 (SOF on first), back-to-back -> one cycle later out0..3=1,0,1,1, frame_valid single pulse, slot=0. Sweep all 16 patterns x 4 slots to mirror the mux-side exhaustive check.
- Same frame with in_valid gaps of 3 idle cycles between each slot -> identical outputs, frame_valid only after slot 3.
- SOF, 1, 1, then SOF again with 0 -> frame_err pulse, outputs unchanged. Continue 0,1,0 -> out=0,0,1,0 (new frame), frame_valid.
- Stream samples without SOF from reset -> no capture, no error. Then assert rst mid-frame (after slot 2) -> state HUNT, outputs 0, no frame_valid.
- TDM_DEMUX_FRAME_CNT_EN defined: 257 good frames -> frame_cnt=1. Undefined build compiles without the port.
